// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle, with the
// divide-by-zero and signed-overflow corner cases answered in a single cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_rsh, div_diff;
  logic [PW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] div_sel, result_c;

  // Operand decode for the acceptance cycle
  assign is_div   = funct3_i[2];
  assign a_signed = (funct3_i != 3'd3) && (funct3_i != 3'd5) && (funct3_i != 3'd7);
  assign b_signed = (funct3_i == 3'd0) || (funct3_i == 3'd1) ||
                    (funct3_i == 3'd4) || (funct3_i == 3'd6);
  assign a_neg    = a_signed & rs1_i[XLEN-1];
  assign b_neg    = b_signed & rs2_i[XLEN-1];
  assign a_mag    = a_neg ? (~rs1_i + XLEN'(1)) : rs1_i;
  assign b_mag    = b_neg ? (~rs2_i + XLEN'(1)) : rs2_i;
  assign div_zero = is_div & (rs2_i == '0);
  assign div_ovf  = is_div & ~funct3_i[0] & (rs1_i == MIN_NEG) & (&rs2_i);

  // Multiply keeps {hi,lo} as product:multiplier; divide keeps remainder:quotient
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign div_rsh  = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_rsh - {1'b0, opb_q};

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? (~prod + PW'(1)) : prod;
  assign div_sel  = op_q[1] ? hi_q : lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    special_d = special_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_c  = '0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          op_d      = funct3_i;
          neg_d     = (is_div & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
          special_d = 1'b0;
          hi_d      = '0;
          cnt_d     = CW'(XLEN);
          state_d   = S_ITER;
          if (is_div) begin
            opb_d = b_mag;
            lo_d  = a_mag;
          end else begin
            opb_d = a_mag;
            lo_d  = b_mag;
          end
          if (div_zero) begin
            special_d = 1'b1;
            lo_d      = funct3_i[1] ? rs1_i : '1;
            state_d   = S_DONE;
          end else if (div_ovf) begin
            special_d = 1'b1;
            lo_d      = funct3_i[1] ? '0 : rs1_i;
            state_d   = S_DONE;
          end
        end
      end
      S_ITER: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_rsh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        // A dropped valid means the core flushed the instruction
        if (!valid_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (special_q) begin
          result_c = lo_q;
        end else if (op_q[2]) begin
          result_c = neg_q ? (~div_sel + XLEN'(1)) : div_sel;
        end else if (op_q == 3'd0) begin
          result_c = prod_fix[XLEN-1:0];
        end else begin
          result_c = prod_fix[PW-1:XLEN];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign done_o   = (state_q == S_DONE);
  assign busy_o   = (state_q != S_IDLE);
  assign stall_o  = valid_i & ~done_o;
  assign result_o = result_c;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer against an arithmetic
// reference model of the RV32M MUL/DIV/REM results and latencies.
module tb_muldiv_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, ps;
    logic [63:0]        pu;
    int                 ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    pu = {32'b0, a} * {32'b0, b};
    ia = a;
    ib = b;
    case (f3)
      3'd0: return pu[31:0];
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * ub; return ps[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Accept an op at the next falling edge (cycle 0) and follow it to done_o
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp_r, got;
    int exp_lat, done_cyc, stall_bad, busy_bad, leak;
    exp_r = model_result(f3, a, b);
    exp_lat = model_latency(f3, a, b);
    @(negedge clk_i);
    valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b;
    #1;
    check({tag, " busy_c0"}, {63'd0, busy_o}, 64'd0);
    stall_bad = (stall_o !== 1'b1) ? 1 : 0;
    leak = (result_o !== 32'd0 || done_o !== 1'b0) ? 1 : 0;
    busy_bad = 0;
    done_cyc = -1;
    got = '0;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk_i);
      rs1_i = $urandom; rs2_i = $urandom;
      #1;
      if (done_o === 1'b1) begin
        done_cyc = c;
        got = result_o;
        check({tag, " stall_at_done"}, {63'd0, stall_o}, 64'd0);
      end else begin
        if (stall_o !== 1'b1) stall_bad++;
        if (busy_o !== 1'b1) busy_bad++;
        if (result_o !== 32'd0) leak++;
      end
    end
    check({tag, " latency"}, 64'(done_cyc), 64'(exp_lat));
    check({tag, " result"}, {32'd0, got}, {32'd0, exp_r});
    check({tag, " stall_bad_cycles"}, 64'(stall_bad), 64'd0);
    check({tag, " busy_bad_cycles"}, 64'(busy_bad), 64'd0);
    check({tag, " result_leak"}, 64'(leak), 64'd0);
    $display("op %s f3=%0d a=%08h b=%08h -> result=%08h expected=%08h done_cycle=%0d",
             tag, f3, a, b, got, exp_r, done_cyc);
  endtask

  task automatic idle_gap();
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    check("gap done", {63'd0, done_o}, 64'd0);
  endtask

  initial begin
    int dones;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    rst_ni = 1'b0; valid_i = 1'b1; funct3_i = 3'd0; rs1_i = '0; rs2_i = '0;
    #2;
    check("reset busy", {63'd0, busy_o}, 64'd0);
    check("reset done", {63'd0, done_o}, 64'd0);
    check("reset result", {32'd0, result_o}, 64'd0);
    check("reset stall_follows_valid", {63'd0, stall_o}, 64'd1);
    valid_i = 1'b0;
    #1;
    check("reset stall_low", {63'd0, stall_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op("MUL_7xneg3", 3'd0, 32'd7, 32'hFFFF_FFFD);       idle_gap();
    run_op("MULH_min", 3'd1, 32'h8000_0000, 32'h8000_0000); idle_gap();
    run_op("MULHU_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle_gap();
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2);          idle_gap();
    run_op("DIVU", 3'd5, 32'd100, 32'd7);                   idle_gap();
    run_op("REMU", 3'd7, 32'd100, 32'd7);                   idle_gap();
    run_op("DIV_neg", 3'd4, 32'hFFFF_FF9C, 32'd7);          idle_gap();
    run_op("REM_neg", 3'd6, 32'hFFFF_FF9C, 32'd7);          idle_gap();
    run_op("DIV_by0", 3'd4, 32'd5, 32'd0);                  idle_gap();
    run_op("REM_by0", 3'd6, 32'd5, 32'd0);                  idle_gap();
    run_op("DIV_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);  idle_gap();
    run_op("REM_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);  idle_gap();

    // Flush: drop valid during ITER of a DIVU
    @(negedge clk_i);
    valid_i = 1'b1; funct3_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3;
    for (int c = 1; c <= 10; c++) @(negedge clk_i);
    #1;
    check("flush busy_before", {63'd0, busy_o}, 64'd1);
    valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("flush busy_after", {63'd0, busy_o}, 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      #1;
      if (done_o === 1'b1) dones++;
    end
    check("flush no_done", 64'(dones), 64'd0);
    $display("op FLUSH DIVU dropped at cycle 10, done pulses seen=%0d", dones);
    run_op("MUL_after_flush", 3'd0, 32'd3, 32'd4); idle_gap();

    // Asynchronous reset mid-ITER
    @(negedge clk_i);
    valid_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9;
    for (int c = 1; c <= 15; c++) @(negedge clk_i);
    #1;
    check("rst busy_before", {63'd0, busy_o}, 64'd1);
    rst_ni = 1'b0;
    #1;
    check("rst busy", {63'd0, busy_o}, 64'd0);
    check("rst done", {63'd0, done_o}, 64'd0);
    check("rst result", {32'd0, result_o}, 64'd0);
    check("rst stall", {63'd0, stall_o}, 64'd1);
    $display("op RESET asserted mid-ITER of MUL 9x9");
    @(negedge clk_i);
    rst_ni = 1'b1; valid_i = 1'b0;
    run_op("MUL_after_reset", 3'd1, 32'hFFFF_FF00, 32'h0001_2345); idle_gap();

    // Back-to-back with valid held high
    run_op("B2B_first", 3'd0, 32'h1234_5678, 32'h0000_0010);
    run_op("B2B_second", 3'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    idle_gap();

    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = ra & 32'h0000_FFFF; rb = rb & 32'h0000_00FF; end
        default: ;
      endcase
      run_op("RAND", rf, ra, rb);
      if ($urandom_range(0, 1) == 0) idle_gap();
    end
    idle_gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
